// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite widths, transfer encodings, response enum and byte-lane helper
package ahb_pkg;

    localparam int AHB_ADDR_WIDTH = 32;
    localparam int AHB_DATA_WIDTH = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    // Little-endian lane mask for an aligned transfer of the given size.
    function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] lane);
        case (size)
            HSIZE_BYTE: return 4'b0001 << lane;
            HSIZE_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            default:    return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_slave_byte_ram.sv
// rtl/ahb_slave_byte_ram.sv - word-organised storage with per-byte write enables and combinational read
module ahb_slave_byte_ram #(
    parameter int DEPTH = 256,
    parameter int DW    = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [DW/8-1:0] be_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [DW-1:0]   wdata_i,
    output logic [DW-1:0]   rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < DW / 8; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Combinational read so a read right after a write sees the new word.
    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_slave_mem.sv
// rtl/ahb_slave_mem.sv - AHB-Lite memory slave with configurable wait states and two-cycle error response
module ahb_slave_mem #(
    parameter int AHB_ADDR_WIDTH = ahb_pkg::AHB_ADDR_WIDTH,
    parameter int AHB_DATA_WIDTH = ahb_pkg::AHB_DATA_WIDTH,
    parameter int MEM_DEPTH      = 256,
    parameter int WAIT_STATES    = 0
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      HSEL,
    input  logic [AHB_ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]                HTRANS,
    input  logic                      HWRITE,
    input  logic [2:0]                HSIZE,
    input  logic [2:0]                HBURST,
    input  logic [3:0]                HPROT,
    input  logic                      HMASTLOCK,
    input  logic                      HREADY,
    input  logic [AHB_DATA_WIDTH-1:0] HWDATA,
    output logic [AHB_DATA_WIDTH-1:0] HRDATA,
    output logic                      HREADYOUT,
    output logic                      HRESP
);
    import ahb_pkg::*;

    localparam int              AW      = $clog2(MEM_DEPTH);
    localparam int              IW      = AHB_ADDR_WIDTH - 2;
    localparam logic [IW-1:0]   DEPTH_W = IW'(MEM_DEPTH);
    localparam logic [2:0]      WS_W    = 3'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_e;

    state_e        state_q;
    logic [2:0]    cnt_q;
    logic          dphase_q;
    logic          write_q;
    logic          hreadyout_q;
    hresp_e        hresp_q;
    logic [AW-1:0] idx_q;
    logic [1:0]    lane_q;
    logic [2:0]    size_q;

    logic                      accept;
    logic                      misaligned;
    logic                      bad_xfer;
    logic                      ram_we;
    logic [AHB_DATA_WIDTH-1:0] ram_rdata;
    logic                      unused_ok;

    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

    assign accept = HSEL && HREADY && HTRANS[1];

    always_comb begin
        misaligned = 1'b0;
        case (HSIZE)
            HSIZE_HALF: misaligned = HADDR[0];
            HSIZE_WORD: misaligned = |HADDR[1:0];
            default:    misaligned = 1'b0;
        endcase
    end

    assign bad_xfer = (HADDR[AHB_ADDR_WIDTH-1:2] >= DEPTH_W) || (HSIZE > HSIZE_WORD) || misaligned;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dphase_q    <= 1'b0;
            write_q     <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            idx_q       <= '0;
            lane_q      <= '0;
            size_q      <= '0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (cnt_q == 3'd1) begin
                        state_q     <= ST_IDLE;
                        cnt_q       <= '0;
                        hreadyout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                ST_ERR1: begin
                    state_q     <= ST_ERR2;
                    hreadyout_q <= 1'b1;
                end
                // IDLE and ERR2 are both final data-phase cycles, so both sample a new address.
                default: begin
                    state_q     <= ST_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_OKAY;
                    dphase_q    <= 1'b0;
                    if (accept) begin
                        if (bad_xfer) begin
                            state_q     <= ST_ERR1;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= HRESP_ERROR;
                        end else begin
                            dphase_q <= 1'b1;
                            write_q  <= HWRITE;
                            idx_q    <= HADDR[AW+1:2];
                            lane_q   <= HADDR[1:0];
                            size_q   <= HSIZE;
                            if (WAIT_STATES > 0) begin
                                state_q     <= ST_WAIT;
                                cnt_q       <= WS_W;
                                hreadyout_q <= 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign ram_we    = dphase_q && write_q && hreadyout_q;
    assign HRDATA    = (dphase_q && !write_q && hreadyout_q) ? ram_rdata : '0;
    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;

    ahb_slave_byte_ram #(
        .DEPTH (MEM_DEPTH),
        .DW    (AHB_DATA_WIDTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (HCLK),
        .we_i    (ram_we),
        .be_i    (byte_lanes(size_q, lane_q)),
        .addr_i  (idx_q),
        .wdata_i (HWDATA),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb/tb_ahb_slave_mem.sv - scoreboard bench for ahb_slave_mem with zero and three wait states
module tb_ahb_slave_mem;
    import ahb_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        hsel [2];
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic        hreadyout [2];
    logic        hresp [2];
    logic [31:0] hrdata [2];

    always #5 HCLK = ~HCLK;

    ahb_slave_mem #(.WAIT_STATES(0)) dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[0]), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
        .HREADY(hreadyout[0]), .HWDATA(HWDATA), .HRDATA(hrdata[0]), .HREADYOUT(hreadyout[0]),
        .HRESP(hresp[0])
    );

    ahb_slave_mem #(.WAIT_STATES(3)) dut3 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[1]), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
        .HREADY(hreadyout[1]), .HWDATA(HWDATA), .HRDATA(hrdata[1]), .HREADYOUT(hreadyout[1]),
        .HRESP(hresp[1])
    );

    typedef struct {
        logic [1:0]  trans;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } op_t;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        resp;
        int          waits;
    } exp_t;

    op_t         ops [$];
    exp_t        sb [$];
    logic [31:0] mem_m [2][256];
    int          n_checks = 0;
    int          n_pass = 0;
    logic        pend [2] = '{1'b0, 1'b0};
    int          lowc [2] = '{0, 0};
    logic        lowr [2] = '{1'b0, 1'b0};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic add_op(input logic [1:0] t, input logic w, input logic [31:0] a,
                          input logic [2:0] s, input logic [31:0] d);
        op_t o;
        o.trans = t; o.wr = w; o.addr = a; o.size = s; o.wdata = d;
        ops.push_back(o);
    endtask

    task automatic push_expect(input int d, input op_t o);
        exp_t        e;
        int          nb;
        int          lo;
        logic [31:0] idx;
        idx     = o.addr >> 2;
        nb      = 1 << o.size;
        lo      = int'(o.addr[1:0]);
        e.tag   = $sformatf("d%0d_%s_%08h", d, o.wr ? "wr" : "rd", o.addr);
        e.rdata = '0;
        e.resp  = 1'b0;
        e.waits = (d == 1) ? 3 : 0;
        if (idx >= 256 || o.size > 3'd2 || (lo % nb) != 0) begin
            e.resp  = 1'b1;
            e.waits = 1;
        end else if (o.wr) begin
            for (int b = 0; b < 4; b++)
                if (b >= lo && b < lo + nb) mem_m[d][idx][b*8 +: 8] = o.wdata[b*8 +: 8];
        end else begin
            e.rdata = mem_m[d][idx];
        end
        sb.push_back(e);
    endtask

    task automatic wait_ready(input int d);
        int n;
        n = 0;
        do begin
            @(negedge HCLK);
            n++;
        end while (!hreadyout[d] && n < 50);
        if (n >= 50) check_eq($sformatf("d%0d_ready_timeout", d), 32'd0, 32'd1);
        @(posedge HCLK);
        #1;
    endtask

    task automatic run_ops(input int d);
        op_t prev;
        bit  have_prev;
        have_prev = 0;
        foreach (ops[i]) begin
            hsel[d] = 1'b1;
            HADDR   = ops[i].addr;
            HTRANS  = ops[i].trans;
            HWRITE  = ops[i].wr;
            HSIZE   = ops[i].size;
            HWDATA  = have_prev ? prev.wdata : 32'h0;
            wait_ready(d);
            if (ops[i].trans[1]) push_expect(d, ops[i]);
            prev      = ops[i];
            have_prev = 1;
        end
        hsel[d] = 1'b0;
        HTRANS  = HTRANS_IDLE;
        if (have_prev) begin
            HWDATA = prev.wdata;
            wait_ready(d);
        end
        HWDATA = 32'h0;
        ops.delete();
    endtask

    always @(negedge HCLK) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (!HRESETn) begin
                pend[d] = 1'b0;
                lowc[d] = 0;
                lowr[d] = 1'b0;
            end else begin
                if (pend[d]) begin
                    if (hreadyout[d]) begin
                        if (sb.size() == 0) begin
                            check_eq($sformatf("d%0d_sb_empty", d), 32'd1, 32'd0);
                        end else begin
                            e = sb.pop_front();
                            check_eq({e.tag, "_rdata"}, hrdata[d], e.rdata);
                            check_eq({e.tag, "_resp"}, {30'b0, hresp[d], lowr[d]}, {30'b0, e.resp, e.resp});
                            check_eq({e.tag, "_waits"}, lowc[d], e.waits);
                        end
                        pend[d] = 1'b0;
                    end else begin
                        lowc[d]++;
                        lowr[d] = lowr[d] | hresp[d];
                    end
                end else begin
                    check_eq($sformatf("d%0d_idle", d), {29'b0, hreadyout[d], hresp[d], |hrdata[d]}, 32'b100);
                end
                if (hreadyout[d] && hsel[d] && HTRANS[1]) begin
                    pend[d] = 1'b1;
                    lowc[d] = 0;
                    lowr[d] = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          a;
        int          s;
        logic [1:0]  t;
        hsel[0] = 1'b0; hsel[1] = 1'b0;
        HADDR = '0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HSIZE = '0; HWDATA = '0;
        HBURST = '0; HPROT = '0; HMASTLOCK = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("d%0d_rst_hreadyout", d), hreadyout[d], 32'd1);
            check_eq($sformatf("d%0d_rst_hresp", d), hresp[d], 32'd0);
            check_eq($sformatf("d%0d_rst_hrdata", d), hrdata[d], 32'd0);
        end
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 32; i++) add_op(HTRANS_NONSEQ, 1'b1, i * 4, HSIZE_WORD, $urandom);
            run_ops(d);
        end

        add_op(HTRANS_NONSEQ, 1'b1, 32'h10, HSIZE_WORD, 32'hDEADBEEF);
        add_op(HTRANS_NONSEQ, 1'b0, 32'h10, HSIZE_WORD, 32'h0);
        run_ops(0);

        for (int d = 0; d < 2; d++) begin
            add_op(HTRANS_NONSEQ, 1'b1, 32'h20, HSIZE_WORD, 32'h11223344);
            add_op(HTRANS_NONSEQ, 1'b1, 32'h21, HSIZE_BYTE, 32'h0000AA00);
            add_op(HTRANS_NONSEQ, 1'b0, 32'h20, HSIZE_WORD, 32'h0);
            add_op(HTRANS_NONSEQ, 1'b1, 32'h32, HSIZE_HALF, 32'hBEEF0000);
            add_op(HTRANS_NONSEQ, 1'b0, 32'h30, HSIZE_WORD, 32'h0);
            run_ops(d);
        end

        add_op(HTRANS_NONSEQ, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
        run_ops(1);

        add_op(HTRANS_NONSEQ, 1'b1, 32'h400, HSIZE_WORD, 32'hCAFEF00D);
        add_op(HTRANS_NONSEQ, 1'b1, 32'h3, HSIZE_HALF, 32'h55660000);
        add_op(HTRANS_NONSEQ, 1'b0, 32'h4, 3'd3, 32'h0);
        add_op(HTRANS_NONSEQ, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
        add_op(HTRANS_NONSEQ, 1'b0, 32'h4, HSIZE_WORD, 32'h0);
        run_ops(0);
        add_op(HTRANS_NONSEQ, 1'b1, 32'h400, HSIZE_WORD, 32'hCAFEF00D);
        add_op(HTRANS_NONSEQ, 1'b1, 32'h6, HSIZE_WORD, 32'h77777777);
        add_op(HTRANS_NONSEQ, 1'b0, 32'h4, HSIZE_WORD, 32'h0);
        run_ops(1);

        for (int d = 0; d < 2; d++) begin
            add_op(HTRANS_NONSEQ, 1'b1, 32'h40, HSIZE_WORD, 32'hA5A5_0001);
            add_op(HTRANS_BUSY,   1'b1, 32'h44, HSIZE_WORD, 32'hFFFF_FFFF);
            add_op(HTRANS_SEQ,    1'b1, 32'h44, HSIZE_WORD, 32'h5A5A_0002);
            add_op(HTRANS_NONSEQ, 1'b0, 32'h40, HSIZE_WORD, 32'h0);
            add_op(HTRANS_SEQ,    1'b0, 32'h44, HSIZE_WORD, 32'h0);
            run_ops(d);
        end

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 30; i++) begin
                s = $urandom_range(0, 2);
                a = $urandom_range(0, 127) & ~((1 << s) - 1);
                t = ($urandom_range(0, 7) == 0) ? HTRANS_BUSY : HTRANS_NONSEQ;
                add_op(t, 1'($urandom_range(0, 1)), a, 3'(s), $urandom);
            end
            run_ops(d);
        end

        hsel[1] = 1'b1;
        HADDR = 32'h8; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HSIZE = HSIZE_WORD;
        wait_ready(1);
        hsel[1] = 1'b0;
        HTRANS  = HTRANS_IDLE;
        HWDATA  = 32'hBAD0BAD0;
        @(negedge HCLK);
        #2;
        check_eq("d1_wait_before_rst", hreadyout[1], 32'd0);
        HRESETn = 1'b0;
        #1;
        check_eq("d1_rst_mid_hreadyout", hreadyout[1], 32'd1);
        check_eq("d1_rst_mid_hresp", hresp[1], 32'd0);
        check_eq("d1_rst_mid_hrdata", hrdata[1], 32'd0);
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        HWDATA  = 32'h0;
        add_op(HTRANS_NONSEQ, 1'b0, 32'h8, HSIZE_WORD, 32'h0);
        run_ops(1);

        repeat (2) @(posedge HCLK);
        check_eq("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
